mac_operand_writer: RTL and testbench



---
 rtl/mac_operand_writer.sv | 94 +++++++++
 tb/tb_mac_operand_writer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_writer.sv
// Producer for the MAC operand FIFOs: writes DEPTH pairs of arithmetic A/B sequences
// and tracks a golden sum of products for the top-level self-check.
module mac_operand_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned A_START    = 2,
    parameter int unsigned A_STEP     = 1,
    parameter int unsigned B_START    = 119,
    parameter int unsigned B_STEP     = 9
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         a_full,
    input  logic                         b_full,
    output logic                         wren,
    output logic [DATA_WIDTH-1:0]        a_wdata,
    output logic [DATA_WIDTH-1:0]        b_wdata,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [ACC_WIDTH-1:0]         expected_acc,
    output logic                         done
);

    localparam int unsigned CountWidth = $clog2(DEPTH + 1);
    localparam int unsigned ProdWidth  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   a_q;
    logic [DATA_WIDTH-1:0]   b_q;
    logic [CountWidth-1:0]   count_q;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic                    done_q;
    logic [ProdWidth-1:0]    prod;

    // Writes go to both FIFOs together, so either full flag stalls the pair.
    assign wren = (state_q == StFill) && !a_full && !b_full;
    assign prod = ProdWidth'(a_q) * ProdWidth'(b_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= DATA_WIDTH'(A_START);
            b_q     <= DATA_WIDTH'(B_START);
            count_q <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StFill;
                        a_q     <= DATA_WIDTH'(A_START);
                        b_q     <= DATA_WIDTH'(B_START);
                        count_q <= '0;
                        acc_q   <= '0;
                        done_q  <= 1'b0;
                    end
                end
                StFill: begin
                    if (wren) begin
                        count_q <= count_q + 1'b1;
                        acc_q   <= acc_q + ACC_WIDTH'(prod);
                        a_q     <= a_q + DATA_WIDTH'(A_STEP);
                        b_q     <= b_q + DATA_WIDTH'(B_STEP);
                        if (count_q == CountWidth'(DEPTH - 1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign a_wdata      = a_q;
    assign b_wdata      = b_q;
    assign count        = count_q;
    assign expected_acc = acc_q;
    assign done         = done_q;

endmodule

// File: tb/tb_mac_operand_writer.sv
// Scoreboard bench for mac_operand_writer: default, wrapping and narrow-accumulator builds.
module tb_mac_operand_writer;

    logic        clk;
    logic        rst;
    logic        start, a_full, b_full;
    logic        wren;
    logic [7:0]  a_wdata, b_wdata;
    logic [1:0]  state;
    logic [3:0]  count;
    logic [23:0] expected_acc;
    logic        done;

    logic        start1, wren1, done1;
    logic [7:0]  a1, b1;
    logic [1:0]  state1;
    logic [2:0]  count1;
    logic [23:0] acc1;

    logic        start2, wren2, done2;
    logic [7:0]  a2, b2;
    logic [1:0]  state2;
    logic [3:0]  count2;
    logic [11:0] acc2;

    int checks = 0;
    int errors = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    // Hand-computed default sequences.
    localparam logic [7:0] ATab [8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    localparam logic [7:0] BTab [8] = '{8'd119, 8'd128, 8'd137, 8'd146,
                                        8'd155, 8'd164, 8'd173, 8'd182};

    mac_operand_writer u0 (
        .clk(clk), .rst(rst), .start(start), .a_full(a_full), .b_full(b_full),
        .wren(wren), .a_wdata(a_wdata), .b_wdata(b_wdata), .state(state),
        .count(count), .expected_acc(expected_acc), .done(done)
    );

    mac_operand_writer #(
        .DEPTH(4), .A_START(250), .A_STEP(3), .B_START(1), .B_STEP(0)
    ) u1 (
        .clk(clk), .rst(rst), .start(start1), .a_full(1'b0), .b_full(1'b0),
        .wren(wren1), .a_wdata(a1), .b_wdata(b1), .state(state1),
        .count(count1), .expected_acc(acc1), .done(done1)
    );

    mac_operand_writer #(
        .ACC_WIDTH(12)
    ) u2 (
        .clk(clk), .rst(rst), .start(start2), .a_full(1'b0), .b_full(1'b0),
        .wren(wren2), .a_wdata(a2), .b_wdata(b2), .state(state2),
        .count(count2), .expected_acc(acc2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance; writes during reset are abandoned.
    always @(negedge clk) begin
        if (!rst && wren) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0_unexpected_wren: got wren=1 expected no write");
            end else begin
                logic [15:0] e;
                e = q0.pop_front();
                check("u0_a_wdata", {24'b0, a_wdata}, {24'b0, e[15:8]});
                check("u0_b_wdata", {24'b0, b_wdata}, {24'b0, e[7:0]});
            end
        end
        if (a_full || b_full) check("u0_wren_while_full", {31'b0, wren}, 32'd0);
    end

    always @(negedge clk) begin
        if (!rst && wren1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_wren: got wren=1 expected no write");
            end else begin
                logic [15:0] e;
                e = q1.pop_front();
                check("u1_a_wdata", {24'b0, a1}, {24'b0, e[15:8]});
                check("u1_b_wdata", {24'b0, b1}, {24'b0, e[7:0]});
            end
        end
    end

    task automatic push_default(input int n);
        for (int i = 0; i < n; i++) q0.push_back({ATab[i], BTab[i]});
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic fill_cycle(input logic af, input logic bf, input logic exp_wren);
        a_full = af;
        b_full = bf;
        @(negedge clk);
        check("u0_wren", {31'b0, wren}, {31'b0, exp_wren});
        @(posedge clk); #1;
        a_full = 1'b0;
        b_full = 1'b0;
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, "_state"}, {30'b0, state}, 32'd2);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_count"}, {28'b0, count}, 32'd8);
        check({tag, "_acc"}, {8'b0, expected_acc}, 32'h001B58);
        check({tag, "_wren"}, {31'b0, wren}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; a_full = 1'b0; b_full = 1'b0;
        start1 = 1'b0; start2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'b0, state}, 32'd0);
        check("rst_wren", {31'b0, wren}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_a", {24'b0, a_wdata}, 32'd2);
        check("rst_b", {24'b0, b_wdata}, 32'd119);
        check("rst_count", {28'b0, count}, 32'd0);
        check("rst_acc", {8'b0, expected_acc}, 32'd0);
        check("rst_u1_a", {24'b0, a1}, 32'd250);
        @(posedge clk); #1;
        rst = 1'b0;

        // Wrap build: A wraps past 255, B constant.
        q1.push_back({8'd250, 8'd1});
        q1.push_back({8'd253, 8'd1});
        q1.push_back({8'd0, 8'd1});
        q1.push_back({8'd3, 8'd1});
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        check("u1_state", {30'b0, state1}, 32'd2);
        check("u1_count", {29'b0, count1}, 32'd4);
        check("u1_acc", {8'b0, acc1}, 32'h0001FA);

        // Narrow accumulator wraps 7000 mod 4096.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        @(negedge clk);
        check("u2_state", {30'b0, state2}, 32'd2);
        check("u2_done", {31'b0, done2}, 32'd1);
        check("u2_count", {28'b0, count2}, 32'd8);
        check("u2_acc", {20'b0, acc2}, 32'hB58);

        // Unstalled default run.
        push_default(8);
        pulse_start();
        for (int i = 0; i < 8; i++) fill_cycle(1'b0, 1'b0, 1'b1);
        check_done("plain");

        // Backpressure, re-armed from DONE.
        push_default(8);
        pulse_start();
        @(negedge clk);
        check("rearm_count", {28'b0, count}, 32'd0);
        check("rearm_acc", {8'b0, expected_acc}, 32'd0);
        @(posedge clk); #1;
        // The cycle above was an accepted write (flags low).
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b1, 1'b0, 1'b0);
        fill_cycle(1'b1, 1'b0, 1'b0);
        a_full = 1'b1;
        @(negedge clk);
        check("stall_wren", {31'b0, wren}, 32'd0);
        check("stall_a", {24'b0, a_wdata}, 32'd5);
        check("stall_b", {24'b0, b_wdata}, 32'd146);
        check("stall_count", {28'b0, count}, 32'd3);
        @(posedge clk); #1;
        a_full = 1'b0;
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b0, 1'b1, 1'b0);
        fill_cycle(1'b0, 1'b1, 1'b0);
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b0, 1'b0, 1'b1);
        check_done("bp");

        // start during FILL is ignored.
        push_default(8);
        pulse_start();
        fill_cycle(1'b0, 1'b0, 1'b1);
        fill_cycle(1'b0, 1'b0, 1'b1);
        start = 1'b1;
        fill_cycle(1'b0, 1'b0, 1'b1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) fill_cycle(1'b0, 1'b0, 1'b1);
        check_done("start_in_fill");

        // Reset after the 4th write abandons the run.
        push_default(4);
        pulse_start();
        for (int i = 0; i < 4; i++) fill_cycle(1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_state", {30'b0, state}, 32'd0);
        check("midrst_wren", {31'b0, wren}, 32'd0);
        check("midrst_count", {28'b0, count}, 32'd0);
        check("midrst_acc", {8'b0, expected_acc}, 32'd0);
        check("midrst_a", {24'b0, a_wdata}, 32'd2);
        push_default(8);
        pulse_start();
        for (int i = 0; i < 8; i++) fill_cycle(1'b0, 1'b0, 1'b1);
        check_done("after_rst");

        @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
